// File: rtl/cpu_pkg.sv
// Encodings shared by the control FSM and the datapath: opcodes, ALU ops,
// write-back select, FSM states and the decoded instruction class.
package cpu_pkg;

    localparam logic [3:0] OP_NOP  = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_SUB  = 4'b0010;
    localparam logic [3:0] OP_AND  = 4'b0011;
    localparam logic [3:0] OP_OR   = 4'b0100;
    localparam logic [3:0] OP_LDI  = 4'b0101;
    localparam logic [3:0] OP_LD   = 4'b0110;
    localparam logic [3:0] OP_ST   = 4'b0111;
    localparam logic [3:0] OP_JMP  = 4'b1000;
    localparam logic [3:0] OP_HALT = 4'b1111;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_OR  = 2'b11
    } alu_op_e;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_IMM = 2'b01;
    localparam logic [1:0] WB_MEM = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6
    } state_e;

    typedef enum logic [2:0] {
        CLS_NOP  = 3'd0,
        CLS_ALU  = 3'd1,
        CLS_LDI  = 3'd2,
        CLS_LD   = 3'd3,
        CLS_ST   = 3'd4,
        CLS_JMP  = 3'd5,
        CLS_HALT = 3'd6
    } cls_e;

    typedef struct packed {
        cls_e    cls;
        alu_op_e alu_op;
        logic    illegal;
    } ctrl_t;

endpackage

// File: rtl/opcode_decoder.sv
// Pure combinational opcode-to-control decode; undefined opcodes behave as
// NOP but are flagged illegal.
module opcode_decoder
    import cpu_pkg::*;
(
    input  logic [3:0] opcode,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl.cls     = CLS_NOP;
        ctrl.alu_op  = ALU_ADD;
        ctrl.illegal = 1'b0;
        case (opcode)
            OP_NOP:  ctrl.cls = CLS_NOP;
            OP_ADD:  begin ctrl.cls = CLS_ALU; ctrl.alu_op = ALU_ADD; end
            OP_SUB:  begin ctrl.cls = CLS_ALU; ctrl.alu_op = ALU_SUB; end
            OP_AND:  begin ctrl.cls = CLS_ALU; ctrl.alu_op = ALU_AND; end
            OP_OR:   begin ctrl.cls = CLS_ALU; ctrl.alu_op = ALU_OR;  end
            OP_LDI:  ctrl.cls = CLS_LDI;
            OP_LD:   ctrl.cls = CLS_LD;
            OP_ST:   ctrl.cls = CLS_ST;
            OP_JMP:  ctrl.cls = CLS_JMP;
            OP_HALT: ctrl.cls = CLS_HALT;
            default: ctrl.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/control_fsm.sv
// Multi-cycle instruction sequencer: fetch, decode, execute, memory access
// and write-back control strobes for a small accumulator-style core.
//
//  state  | meaning
//  IDLE   | one cycle after reset release
//  FETCH  | instruction read, waits for mem_ready_i
//  DECODE | opcode_i decoded and latched; JMP/illegal strobes here
//  EXEC   | ALU operation
//  MEM    | data read (LD) or write (ST), waits for mem_ready_i
//  WB     | single-cycle register write
//  HALT   | absorbing until reset
module control_fsm
    import cpu_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int SEL_WIDTH  = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic [3:0]           opcode_i,
    input  logic                 mem_ready_i,
    output logic                 ir_load_o,
    output logic                 pc_inc_o,
    output logic                 pc_load_o,
    output logic [1:0]           alu_op_o,
    output logic [SEL_WIDTH-1:0] wb_sel_o,
    output logic                 reg_we_o,
    output logic                 mem_rd_o,
    output logic                 mem_wr_o,
    output logic                 halted_o,
    output logic                 illegal_o
);

    if (SEL_WIDTH < 2 || DATA_WIDTH < 1) begin : g_bad_params
        $error("control_fsm: SEL_WIDTH must be >= 2 and DATA_WIDTH >= 1");
    end

    state_e     state;
    logic [3:0] opcode_q;
    logic [3:0] dec_opcode;
    ctrl_t      dec;

    // The live opcode is only trusted in DECODE; afterwards the latched copy drives decode.
    assign dec_opcode = (state == ST_DECODE) ? opcode_i : opcode_q;

    opcode_decoder u_dec (
        .opcode (dec_opcode),
        .ctrl   (dec)
    );

    assign ir_load_o = (state == ST_FETCH) && mem_ready_i;
    assign pc_inc_o  = (state == ST_FETCH) && mem_ready_i;
    assign pc_load_o = (state == ST_DECODE) && (dec.cls == CLS_JMP);
    assign illegal_o = (state == ST_DECODE) && dec.illegal;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state    <= ST_IDLE;
            opcode_q <= OP_NOP;
            alu_op_o <= ALU_ADD;
            wb_sel_o <= SEL_WIDTH'(WB_ALU);
            reg_we_o <= 1'b0;
            mem_rd_o <= 1'b0;
            mem_wr_o <= 1'b0;
            halted_o <= 1'b0;
        end else begin
            // Registered outputs describe the state being entered; wb_sel_o holds unless set.
            alu_op_o <= ALU_ADD;
            reg_we_o <= 1'b0;
            mem_rd_o <= 1'b0;
            mem_wr_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    state    <= ST_FETCH;
                    mem_rd_o <= 1'b1;
                end
                ST_FETCH: begin
                    if (mem_ready_i) begin
                        state <= ST_DECODE;
                    end else begin
                        mem_rd_o <= 1'b1;
                    end
                end
                ST_DECODE: begin
                    opcode_q <= opcode_i;
                    case (dec.cls)
                        CLS_ALU: begin
                            state    <= ST_EXEC;
                            alu_op_o <= dec.alu_op;
                            wb_sel_o <= SEL_WIDTH'(WB_ALU);
                        end
                        CLS_LDI: begin
                            state    <= ST_WB;
                            reg_we_o <= 1'b1;
                            wb_sel_o <= SEL_WIDTH'(WB_IMM);
                        end
                        CLS_LD: begin
                            state    <= ST_MEM;
                            mem_rd_o <= 1'b1;
                            wb_sel_o <= SEL_WIDTH'(WB_MEM);
                        end
                        CLS_ST: begin
                            state    <= ST_MEM;
                            mem_wr_o <= 1'b1;
                        end
                        CLS_HALT: begin
                            state    <= ST_HALT;
                            halted_o <= 1'b1;
                            wb_sel_o <= SEL_WIDTH'(WB_ALU);
                        end
                        default: begin
                            state    <= ST_FETCH;
                            mem_rd_o <= 1'b1;
                        end
                    endcase
                end
                ST_EXEC: begin
                    state    <= ST_WB;
                    reg_we_o <= 1'b1;
                    alu_op_o <= dec.alu_op;
                end
                ST_MEM: begin
                    if (mem_ready_i) begin
                        if (dec.cls == CLS_LD) begin
                            state    <= ST_WB;
                            reg_we_o <= 1'b1;
                        end else begin
                            state    <= ST_FETCH;
                            mem_rd_o <= 1'b1;
                        end
                    end else begin
                        mem_rd_o <= (dec.cls == CLS_LD);
                        mem_wr_o <= (dec.cls == CLS_ST);
                    end
                end
                ST_WB: begin
                    state    <= ST_FETCH;
                    mem_rd_o <= 1'b1;
                end
                ST_HALT: begin
                    state <= ST_HALT;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
